data_memory_responder: RTL and testbench

- Data-memory side of the datapath's load/store interface; responds to the MemRead/MemWrite strobes issued by the main control unit.
- Services single-word lw/sw requests against an internal block-RAM array with a configurable multi-cycle read latency.
- Signals completion with a one-cycle MemReady pulse and flags malformed requests, so a multicycle datapath can stall on Busy.

---
 rtl/data_memory_responder.sv | 103 ++++++++++
 tb/tb_data_memory_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder for the multicycle datapath: serialises single-word
// lw/sw requests against an internal word array and signals completion on MemReady.
module data_memory_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemReady,
  output logic                  ReqError,
  output logic                  Busy
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      counter;
  logic [ADDR_WIDTH-1:0] capIndex;
  logic [DATA_WIDTH-1:0] capData;
  logic                  capWrite;
  logic                  capError;
  logic                  reqValid;
  logic                  reqBad;
  logic                  commit;
  logic                  unusedAddrBits;

  logic [DATA_WIDTH-1:0] memArray [2**ADDR_WIDTH];

  // Upper address bits alias onto the array and are deliberately not decoded.
  assign unusedAddrBits = ^Address[31:ADDR_WIDTH+2];

  assign reqValid = MemRead | MemWrite;
  assign reqBad   = (MemRead & MemWrite) | (Address[1:0] != 2'b00);
  assign commit   = (state == ACCESS) && (counter == '0);

  assign Busy     = (state != IDLE);
  assign MemReady = (state == RESP);
  assign ReqError = (state == RESP) && capError;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      counter  <= '0;
      capIndex <= '0;
      capData  <= '0;
      capWrite <= 1'b0;
      capError <= 1'b0;
      ReadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            capIndex <= Address[ADDR_WIDTH+1:2];
            capData  <= WriteData;
            capWrite <= MemWrite;
            capError <= reqBad;
            if (reqBad) begin
              state <= RESP;
            end else begin
              state   <= ACCESS;
              counter <= MemWrite ? '0 : CNT_W'(READ_LATENCY - 1);
            end
          end
        end
        ACCESS: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            if (!capWrite) begin
              ReadData <= memArray[capIndex];
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array port kept out of the reset domain so it maps onto block RAM;
  // an aborted write never reaches here because reset forces state to IDLE.
  always_ff @(posedge CLK) begin
    if (commit && capWrite) begin
      memArray[capIndex] <= capData;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (read latency 2 and 1) driven
// by directed and random transactions, checked every cycle against an edge-count model.
module tb_data_memory_responder;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        memRead [2];
  logic        memWrite [2];
  logic [31:0] address [2];
  logic [31:0] writeData [2];
  logic [31:0] readDataS [2];
  logic        readyS [2];
  logic        reqErrS [2];
  logic        busyS [2];

  int assertCount = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  always #5 CLK = ~CLK;

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2)) dut0 (
    .CLK(CLK), .Reset(Reset), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
    .Address(address[0]), .WriteData(writeData[0]), .ReadData(readDataS[0]),
    .MemReady(readyS[0]), .ReqError(reqErrS[0]), .Busy(busyS[0])
  );

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
    .Address(address[1]), .WriteData(writeData[1]), .ReadData(readDataS[1]),
    .MemReady(readyS[1]), .ReqError(reqErrS[1]), .Busy(busyS[1])
  );

  // Reference model: each accepted request is described by the edge number
  // at which its response appears; everything else follows by arithmetic.
  int          modelLat [2] = '{2, 1};
  int          edgeCnt = 0;
  bit          mActive [2] = '{1'b0, 1'b0};
  int          mRespEdge [2] = '{0, 0};
  bit          mErr [2] = '{1'b0, 1'b0};
  bit          mWrite [2] = '{1'b0, 1'b0};
  int          mIdx [2] = '{0, 0};
  logic [31:0] mData [2] = '{32'h0, 32'h0};
  logic [31:0] mRd [2] = '{32'h0, 32'h0};
  bit          mRdKnown [2] = '{1'b1, 1'b1};
  logic [31:0] memModel [int];

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        mActive[i]  = 1'b0;
        mRd[i]      = 32'h0;
        mRdKnown[i] = 1'b1;
      end
    end else begin
      edgeCnt++;
      for (int i = 0; i < 2; i++) begin
        if (mActive[i]) begin
          if (edgeCnt == mRespEdge[i] + 1) begin
            mActive[i] = 1'b0;
          end else if (edgeCnt == mRespEdge[i] && !mErr[i]) begin
            if (mWrite[i]) begin
              memModel[i * 256 + mIdx[i]] = mData[i];
            end else if (memModel.exists(i * 256 + mIdx[i])) begin
              mRd[i]      = memModel[i * 256 + mIdx[i]];
              mRdKnown[i] = 1'b1;
            end else begin
              mRdKnown[i] = 1'b0;
            end
          end
        end else if (memRead[i] || memWrite[i]) begin
          mActive[i]   = 1'b1;
          mWrite[i]    = memWrite[i];
          mIdx[i]      = int'(address[i][9:2]);
          mData[i]     = writeData[i];
          mErr[i]      = (memRead[i] && memWrite[i]) || (address[i][1:0] != 2'b00);
          mRespEdge[i] = edgeCnt + (mErr[i] ? 0 : (memWrite[i] ? 1 : modelLat[i]));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (checkEn && !Reset) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("busy%0d", i), 32'(busyS[i]), 32'(mActive[i]));
        checkOutput($sformatf("ready%0d", i), 32'(readyS[i]),
                    32'(mActive[i] && edgeCnt == mRespEdge[i]));
        checkOutput($sformatf("reqError%0d", i), 32'(reqErrS[i]),
                    32'(mActive[i] && edgeCnt == mRespEdge[i] && mErr[i]));
        if (mRdKnown[i]) begin
          checkOutput($sformatf("readData%0d", i), readDataS[i], mRd[i]);
        end
      end
    end
  end

  // One request held for a single sampling edge; readyAt counts falling edges
  // from the sample to the first MemReady (-1 if it never comes).
  task automatic applyStimulus(input int sel, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               output int readyAt, output logic [31:0] rdVal, output bit errVal);
    readyAt = -1;
    rdVal   = 32'h0;
    errVal  = 1'b0;
    @(negedge CLK);
    #1;
    memRead[sel]   = rd;
    memWrite[sel]  = wr;
    address[sel]   = addr;
    writeData[sel] = data;
    @(posedge CLK);
    #1;
    memRead[sel]  = 1'b0;
    memWrite[sel] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (readyS[sel]) begin
        readyAt = c;
        rdVal   = readDataS[sel];
        errVal  = reqErrS[sel];
        break;
      end
    end
    if (readyAt < 0) begin
      failCount++;
      assertCount++;
      $display("[TB] FAIL timeout dut%0d addr=%h no MemReady within 20 cycles", sel, addr);
    end
  endtask

  int          rAt;
  logic [31:0] rVal;
  bit          rErr;
  int          pulses;
  int          firstAt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      memRead[i] = 1'b0; memWrite[i] = 1'b0; address[i] = 32'h0; writeData[i] = 32'h0;
    end
    repeat (2) @(negedge CLK);
    checkOutput("resetReadData", readDataS[0], 32'h0);
    checkOutput("resetBusy", 32'(busyS[0]), 32'h0);
    #1;
    Reset = 1'b0;
    checkEn = 1'b1;

    $display("[TB] store then load");
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rAt, rVal, rErr);
    checkOutput("storeLatency", 32'(rAt), 32'd2);
    checkOutput("storeErr", 32'(rErr), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, rAt, rVal, rErr);
    checkOutput("loadLatency", 32'(rAt), 32'd3);
    checkOutput("loadData", rVal, 32'hDEADBEEF);

    $display("[TB] misaligned load");
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, rAt, rVal, rErr);
    checkOutput("misalignLatency", 32'(rAt), 32'd1);
    checkOutput("misalignErr", 32'(rErr), 32'd1);
    checkOutput("misalignReadData", rVal, 32'hDEADBEEF);

    $display("[TB] asynchronous reset mid-cycle");
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    checkOutput("asyncReadData", readDataS[0], 32'h0);
    checkOutput("asyncReady", 32'(readyS[0]), 32'h0);
    checkOutput("asyncBusy", 32'(busyS[0]), 32'h0);
    #1 Reset = 1'b0;

    $display("[TB] conflict");
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, rAt, rVal, rErr);
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h1234, rAt, rVal, rErr);
    checkOutput("conflictErr", 32'(rErr), 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, rAt, rVal, rErr);
    checkOutput("conflictKeeps", rVal, 32'hA5A5A5A5);

    $display("[TB] aliasing");
    applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'hCAFE0001, rAt, rVal, rErr);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, rAt, rVal, rErr);
    checkOutput("aliasData", rVal, 32'hCAFE0001);

    $display("[TB] strobe toggled while busy");
    @(negedge CLK);
    #1 memRead[0] = 1'b1; address[0] = 32'h10;
    @(posedge CLK);
    #1 memRead[0] = 1'b0; memWrite[0] = 1'b1; writeData[0] = 32'h77; address[0] = 32'h20;
    pulses = 0;
    firstAt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (readyS[0]) begin
        pulses++;
        if (firstAt == 0) firstAt = c;
      end
      if (c == 2) #1 memWrite[0] = 1'b0;
    end
    checkOutput("busyIgnorePulses", 32'(pulses), 32'd1);
    checkOutput("busyIgnoreAt", 32'(firstAt), 32'd3);

    $display("[TB] reset aborts uncommitted write");
    applyStimulus(0, 1'b0, 1'b1, 32'h8, 32'h11112222, rAt, rVal, rErr);
    @(negedge CLK);
    #1 memWrite[0] = 1'b1; address[0] = 32'h8; writeData[0] = 32'h55AA55AA;
    @(posedge CLK);
    #1 memWrite[0] = 1'b0;
    #1 Reset = 1'b1;
    #1 checkOutput("abortBusy", 32'(busyS[0]), 32'h0);
    #1 Reset = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (readyS[0]) pulses++;
    end
    checkOutput("abortNoReady", 32'(pulses), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0, rAt, rVal, rErr);
    checkOutput("abortOldData", rVal, 32'h11112222);

    $display("[TB] read latency 1 instance");
    applyStimulus(1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, rAt, rVal, rErr);
    applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h0, rAt, rVal, rErr);
    checkOutput("lat1Latency", 32'(rAt), 32'd2);
    checkOutput("lat1Data", rVal, 32'h0BADF00D);

    $display("[TB] random transactions");
    for (int n = 0; n < 120; n++) begin
      int          sel;
      int          kind;
      logic [31:0] addr;
      bit          rd;
      bit          wr;
      sel  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      rd   = (kind < 4) || (kind >= 8);
      wr   = (kind >= 4);
      addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFFFC00);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      applyStimulus(sel, rd, wr, addr, $urandom, rAt, rVal, rErr);
    end

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
